// File: rtl/turn_signal_input_conditioner.sv
// turn_signal_input_conditioner
//
// Front end for the turn-signal Moore FSM. Raw lever switches and the raw
// emergency push-button come straight from board pins. Each bit passes
// through a 2-flop synchronizer and is then debounced. The lever code is
// mapped onto the FSM's ADI input. Invalid codes are flagged. The momentary
// button is turned into a latched emergency level E by a small toggle FSM.
//
// Ports:
//   clk            board clock (50 MHz)
//   reset          asynchronous, active-high reset for every flop
//   lever_raw      raw lever pins: 00 off, 01 right, 10 left, 11 invalid
//   emerg_btn_raw  raw emergency push-button, 1 = pressed
//   ADI            conditioned lever code to the FSM
//   E              latched emergency request to the FSM
//   lever_invalid  high while the debounced lever reads 11
//   emerg_pulse    one-cycle strobe coincident with every E toggle
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a new value
//                    (legal range 2 .. 2**CNT_W-1)
//   CNT_W            width of each debounce counter
//
// Optional build macro:
//   TURN_LEVER_HOLD_EN  when defined, an invalid lever code (11) keeps ADI
//                       at its last valid code instead of forcing 00.

module turn_signal_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] lever_raw,
    input  logic       emerg_btn_raw,
    output logic [1:0] ADI,
    output logic       E,
    output logic       lever_invalid,
    output logic       emerg_pulse
);

    // The edge that would raise a counter to DEBOUNCE_CYCLES-1 accepts the new
    // value instead. The change edge clears the counter and counts as the first
    // stable cycle. A value is therefore accepted after exactly DEBOUNCE_CYCLES
    // stable samples, and the counter never holds more than DEBOUNCE_CYCLES-2.
    localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        OFF_IDLE = 2'd0,
        ON_HELD  = 2'd1,
        ON_IDLE  = 2'd2,
        OFF_HELD = 2'd3
    } emerg_state_t;

    logic [1:0]       lev_s1_q, lev_s1_d;
    logic [1:0]       lev_s_q, lev_s_d;
    logic [1:0]       lev_prev_q, lev_prev_d;
    logic [1:0]       lev_db_q, lev_db_d;
    logic [CNT_W-1:0] lev_cnt_q, lev_cnt_d;

    logic             btn_s1_q, btn_s1_d;
    logic             btn_s_q, btn_s_d;
    logic             btn_prev_q, btn_prev_d;
    logic             btn_db_q, btn_db_d;
    logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;

    logic [1:0]       adi_q, adi_d;
    logic             lever_invalid_q, lever_invalid_d;

    emerg_state_t     state_q, state_d;
    logic             e_q, e_d;
    logic             emerg_pulse_q, emerg_pulse_d;

    // Two-stage synchronizer chains. The *_prev copies hold the previous
    // cycle's synchronized value so the debouncers can detect a fresh change.
    always_comb begin
        lev_s1_d   = lever_raw;
        lev_s_d    = lev_s1_q;
        lev_prev_d = lev_s_q;
        btn_s1_d   = emerg_btn_raw;
        btn_s_d    = btn_s1_q;
        btn_prev_d = btn_s_q;
    end

    // Lever debounce. The counter runs only while the synchronized code
    // differs from the accepted code and matches the previous cycle.
    // Otherwise it clears, so a glitch restarts the whole stability window.
    always_comb begin
        lev_db_d  = lev_db_q;
        lev_cnt_d = '0;
        if ((lev_s_q != lev_db_q) && (lev_s_q == lev_prev_q)) begin
            if (lev_cnt_q >= ACCEPT_CNT) begin
                lev_db_d = lev_s_q;
            end else begin
                lev_cnt_d = lev_cnt_q + CNT_W'(1);
            end
        end
    end

    // Button debounce. This uses the same rule as the lever and runs on its
    // own counter, so the two inputs never interact.
    always_comb begin
        btn_db_d  = btn_db_q;
        btn_cnt_d = '0;
        if ((btn_s_q != btn_db_q) && (btn_s_q == btn_prev_q)) begin
            if (btn_cnt_q >= ACCEPT_CNT) begin
                btn_db_d = btn_s_q;
            end else begin
                btn_cnt_d = btn_cnt_q + CNT_W'(1);
            end
        end
    end

    // Lever code mapping, registered one cycle after the debounced value.
    // adi_q only ever holds a valid code, so in hold mode it already
    // remembers the last valid lever position.
    always_comb begin
        adi_d           = lev_db_q;
        lever_invalid_d = 1'b0;
        if (lev_db_q == 2'b11) begin
            lever_invalid_d = 1'b1;
`ifdef TURN_LEVER_HOLD_EN
            adi_d = adi_q;
`else
            adi_d = 2'b00;
`endif
        end
    end

    // Emergency toggle FSM. Each debounced press flips E exactly once. The
    // HELD states wait for release, so a held button cannot re-toggle. E and
    // the strobe are registered so the FSM downstream sees clean levels.
    always_comb begin
        state_d       = state_q;
        e_d           = e_q;
        emerg_pulse_d = 1'b0;
        case (state_q)
            OFF_IDLE: begin
                if (btn_db_q) begin
                    state_d       = ON_HELD;
                    e_d           = 1'b1;
                    emerg_pulse_d = 1'b1;
                end
            end
            ON_HELD: begin
                if (!btn_db_q) begin
                    state_d = ON_IDLE;
                end
            end
            ON_IDLE: begin
                if (btn_db_q) begin
                    state_d       = OFF_HELD;
                    e_d           = 1'b0;
                    emerg_pulse_d = 1'b1;
                end
            end
            OFF_HELD: begin
                if (!btn_db_q) begin
                    state_d = OFF_IDLE;
                end
            end
            default: begin
                state_d = OFF_IDLE;
                e_d     = 1'b0;
            end
        endcase
    end

    // All state registers. Reset is asynchronous, so a reset in the middle of
    // a debounce window throws away any partial count immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lev_s1_q        <= 2'b00;
            lev_s_q         <= 2'b00;
            lev_prev_q      <= 2'b00;
            lev_db_q        <= 2'b00;
            lev_cnt_q       <= '0;
            btn_s1_q        <= 1'b0;
            btn_s_q         <= 1'b0;
            btn_prev_q      <= 1'b0;
            btn_db_q        <= 1'b0;
            btn_cnt_q       <= '0;
            adi_q           <= 2'b00;
            lever_invalid_q <= 1'b0;
            state_q         <= OFF_IDLE;
            e_q             <= 1'b0;
            emerg_pulse_q   <= 1'b0;
        end else begin
            lev_s1_q        <= lev_s1_d;
            lev_s_q         <= lev_s_d;
            lev_prev_q      <= lev_prev_d;
            lev_db_q        <= lev_db_d;
            lev_cnt_q       <= lev_cnt_d;
            btn_s1_q        <= btn_s1_d;
            btn_s_q         <= btn_s_d;
            btn_prev_q      <= btn_prev_d;
            btn_db_q        <= btn_db_d;
            btn_cnt_q       <= btn_cnt_d;
            adi_q           <= adi_d;
            lever_invalid_q <= lever_invalid_d;
            state_q         <= state_d;
            e_q             <= e_d;
            emerg_pulse_q   <= emerg_pulse_d;
        end
    end

    assign ADI           = adi_q;
    assign E             = e_q;
    assign lever_invalid = lever_invalid_q;
    assign emerg_pulse   = emerg_pulse_q;

endmodule

// File: tb/tb_turn_signal_input_conditioner.sv
// tb_turn_signal_input_conditioner
//
// Bench for turn_signal_input_conditioner with DEBOUNCE_CYCLES=4. The
// reference model keeps a short history of raw input samples. A debounced
// value changes when the last DEBOUNCE_CYCLES samples seen through the
// 2-cycle synchronizer all agree on a new value. E flips on every rising
// edge of the debounced button. Directed timing checks use constants taken
// from the expected latencies.

module tb_turn_signal_input_conditioner;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic [1:0] lever_raw;
    logic       emerg_btn_raw;
    logic [1:0] ADI;
    logic       E;
    logic       lever_invalid;
    logic       emerg_pulse;

    int checks = 0;
    int passes = 0;

    turn_signal_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lever_raw    (lever_raw),
        .emerg_btn_raw(emerg_btn_raw),
        .ADI          (ADI),
        .E            (E),
        .lever_invalid(lever_invalid),
        .emerg_pulse  (emerg_pulse)
    );

    // 100 MHz bench clock. Only the cycle count matters here.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state. Index j of each history array holds the raw value
    // sampled j edges before the most recent one.
    logic [1:0] m_lev_hist [0:D];
    logic       m_btn_hist [0:D];
    logic [1:0] m_lev_db;
    logic       m_btn_db;
    logic       m_btn_db_prev;
    logic [1:0] m_adi;
    logic       m_inv;
    logic       m_e;
    logic       m_pulse;

    // Behavioural model, evaluated at every clock edge and reset
    // asynchronously together with the design.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= D; i++) begin
                m_lev_hist[i] = 2'b00;
                m_btn_hist[i] = 1'b0;
            end
            m_lev_db      = 2'b00;
            m_btn_db      = 1'b0;
            m_btn_db_prev = 1'b0;
            m_adi         = 2'b00;
            m_inv         = 1'b0;
            m_e           = 1'b0;
            m_pulse       = 1'b0;
        end else begin
            logic [1:0] v;
            logic       b;
            logic       lev_ok;
            logic       btn_ok;
            logic       tog;
            if (m_lev_db == 2'b11) begin
                m_inv = 1'b1;
`ifndef TURN_LEVER_HOLD_EN
                m_adi = 2'b00;
`endif
            end else begin
                m_inv = 1'b0;
                m_adi = m_lev_db;
            end
            tog     = m_btn_db && !m_btn_db_prev;
            m_e     = m_e ^ tog;
            m_pulse = tog;
            v       = m_lev_hist[1];
            b       = m_btn_hist[1];
            lev_ok  = (v != m_lev_db);
            btn_ok  = (b != m_btn_db);
            for (int i = 2; i <= D; i++) begin
                if (m_lev_hist[i] != v) lev_ok = 1'b0;
                if (m_btn_hist[i] != b) btn_ok = 1'b0;
            end
            m_btn_db_prev = m_btn_db;
            if (lev_ok) m_lev_db = v;
            if (btn_ok) m_btn_db = b;
            for (int i = D; i > 0; i--) begin
                m_lev_hist[i] = m_lev_hist[i - 1];
                m_btn_hist[i] = m_btn_hist[i - 1];
            end
            m_lev_hist[0] = lever_raw;
            m_btn_hist[0] = emerg_btn_raw;
        end
    end

    // Reset state. The first check happens before any clock edge, so the
    // reset must act asynchronously.
    task automatic test_reset();
        reset         = 1'b1;
        lever_raw     = 2'b00;
        emerg_btn_raw = 1'b0;
        #3;
        checks++;
        if ({ADI, E, lever_invalid, emerg_pulse} !== 5'b00000)
            $display("[TB] FAIL reset_async: observed %b, expected 00000",
                     {ADI, E, lever_invalid, emerg_pulse});
        else passes++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({ADI, E, lever_invalid, emerg_pulse} !== 5'b00000)
                $display("[TB] FAIL reset_idle: observed %b, expected 00000",
                         {ADI, E, lever_invalid, emerg_pulse});
            else passes++;
        end
    endtask

    // Lever 00 -> 01 with the input held steady. ADI must appear exactly 7
    // clocks after the change.
    task automatic test_lever_change();
        logic [1:0] exp_adi;
        @(negedge clk);
        lever_raw = 2'b01;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            exp_adi = (n >= 7) ? 2'b01 : 2'b00;
            checks++;
            if (ADI !== exp_adi || lever_invalid !== 1'b0)
                $display("[TB] FAIL lever_latency n=%0d: observed ADI=%b inv=%b, expected ADI=%b inv=0",
                         n, ADI, lever_invalid, exp_adi);
            else passes++;
            checks++;
            if ({ADI, E, lever_invalid, emerg_pulse} !== {m_adi, m_e, m_inv, m_pulse})
                $display("[TB] FAIL lever_model: observed %b, expected %b",
                         {ADI, E, lever_invalid, emerg_pulse}, {m_adi, m_e, m_inv, m_pulse});
            else passes++;
        end
        lever_raw = 2'b00;
        repeat (12) @(negedge clk);
    endtask

    // A 3-cycle glitch is one cycle too short to be accepted.
    task automatic test_glitch();
        lever_raw = 2'b10;
        repeat (3) @(negedge clk);
        lever_raw = 2'b00;
        repeat (15) begin
            @(negedge clk);
            checks++;
            if (ADI !== 2'b00 || lever_invalid !== 1'b0)
                $display("[TB] FAIL glitch_ignored: observed ADI=%b inv=%b, expected ADI=00 inv=0",
                         ADI, lever_invalid);
            else passes++;
        end
    endtask

    // Press, release, press again. Each press toggles E exactly once with a
    // single strobe. Releasing the button never toggles.
    task automatic test_emergency_toggle();
        int pulses;
        pulses = 0;
        emerg_btn_raw = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (emerg_pulse === 1'b1) pulses++;
            checks++;
            if (E !== (n >= 7) || emerg_pulse !== (n == 7))
                $display("[TB] FAIL press1_timing n=%0d: observed E=%b pulse=%b, expected E=%b pulse=%b",
                         n, E, emerg_pulse, (n >= 7), (n == 7));
            else passes++;
        end
        emerg_btn_raw = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (emerg_pulse === 1'b1) pulses++;
            checks++;
            if (E !== 1'b1 || emerg_pulse !== 1'b0)
                $display("[TB] FAIL release_hold n=%0d: observed E=%b pulse=%b, expected E=1 pulse=0",
                         n, E, emerg_pulse);
            else passes++;
        end
        emerg_btn_raw = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (emerg_pulse === 1'b1) pulses++;
            checks++;
            if (E !== (n < 7) || emerg_pulse !== (n == 7))
                $display("[TB] FAIL press2_timing n=%0d: observed E=%b pulse=%b, expected E=%b pulse=%b",
                         n, E, emerg_pulse, (n < 7), (n == 7));
            else passes++;
        end
        checks++;
        if (pulses != 2)
            $display("[TB] FAIL pulse_count: observed %0d, expected 2", pulses);
        else passes++;
        emerg_btn_raw = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // An invalid lever code after a valid left signal.
    task automatic test_invalid_lever();
        logic [1:0] exp_adi;
`ifdef TURN_LEVER_HOLD_EN
        exp_adi = 2'b10;
`else
        exp_adi = 2'b00;
`endif
        lever_raw = 2'b10;
        repeat (12) @(negedge clk);
        checks++;
        if (ADI !== 2'b10 || lever_invalid !== 1'b0)
            $display("[TB] FAIL left_before_invalid: observed ADI=%b inv=%b, expected ADI=10 inv=0",
                     ADI, lever_invalid);
        else passes++;
        lever_raw = 2'b11;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            checks++;
            if ({ADI, E, lever_invalid, emerg_pulse} !== {m_adi, m_e, m_inv, m_pulse})
                $display("[TB] FAIL invalid_model n=%0d: observed %b, expected %b",
                         n, {ADI, E, lever_invalid, emerg_pulse}, {m_adi, m_e, m_inv, m_pulse});
            else passes++;
        end
        checks++;
        if (ADI !== exp_adi || lever_invalid !== 1'b1)
            $display("[TB] FAIL invalid_map: observed ADI=%b inv=%b, expected ADI=%b inv=1",
                     ADI, lever_invalid, exp_adi);
        else passes++;
    endtask

    // Asynchronous reset in the middle of a lever debounce while E=1. The
    // held lever must then go through the full latency again.
    task automatic test_reset_mid_debounce();
        logic [1:0] exp_adi;
        emerg_btn_raw = 1'b1;
        repeat (10) @(negedge clk);
        emerg_btn_raw = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (E !== 1'b1)
            $display("[TB] FAIL e_set_before_reset: observed %b, expected 1", E);
        else passes++;
        lever_raw = 2'b01;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ADI, E, lever_invalid, emerg_pulse} !== 5'b00000)
            $display("[TB] FAIL reset_mid_debounce: observed %b, expected 00000",
                     {ADI, E, lever_invalid, emerg_pulse});
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            exp_adi = (n >= 7) ? 2'b01 : 2'b00;
            checks++;
            if (ADI !== exp_adi || E !== 1'b0)
                $display("[TB] FAIL reaccept n=%0d: observed ADI=%b E=%b, expected ADI=%b E=0",
                         n, ADI, E, exp_adi);
            else passes++;
        end
    endtask

    // Lever change and button press on the same cycle. The two are
    // independent, so both land 7 clocks later with one strobe.
    task automatic test_simultaneous();
        logic [1:0] exp_adi;
        repeat (4) @(negedge clk);
        lever_raw     = 2'b10;
        emerg_btn_raw = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            exp_adi = (n >= 7) ? 2'b10 : 2'b01;
            checks++;
            if (ADI !== exp_adi || E !== (n >= 7) || emerg_pulse !== (n == 7))
                $display("[TB] FAIL simultaneous n=%0d: observed ADI=%b E=%b pulse=%b, expected ADI=%b E=%b pulse=%b",
                         n, ADI, E, emerg_pulse, exp_adi, (n >= 7), (n == 7));
            else passes++;
        end
        emerg_btn_raw = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // Random lever codes and button levels held for random lengths, some
    // shorter and some longer than the debounce window. Every cycle is
    // compared against the model.
    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 70; seg++) begin
            lever_raw     = 2'($urandom_range(0, 3));
            emerg_btn_raw = 1'($urandom_range(0, 1));
            hold          = $urandom_range(1, 9);
            repeat (hold) begin
                @(negedge clk);
                checks++;
                if ({ADI, E, lever_invalid, emerg_pulse} !== {m_adi, m_e, m_inv, m_pulse})
                    $display("[TB] FAIL random_model seg=%0d: observed %b, expected %b",
                             seg, {ADI, E, lever_invalid, emerg_pulse}, {m_adi, m_e, m_inv, m_pulse});
                else passes++;
            end
        end
    endtask

    // Test sequence and summary.
    initial begin
        test_reset();
        test_lever_change();
        test_glitch();
        test_emergency_toggle();
        test_invalid_lever();
        test_reset_mid_debounce();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
